// File: rtl/pipe_stage_buf_if.sv
// Valid/ready channel carrying one DW-bit pipeline payload.
// Handshake: a beat transfers on a rising clk edge where valid=1 and ready=1. The master
// holds valid and data until that edge. ready may depend only on the receiver's state.
interface pipe_stage_buf_if #(
  parameter int DW = 65
);
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register with a 2-entry skid buffer and a synchronous flush.
// Optional macro PIPE_STAGE_PERF_EN adds a saturating downstream-stall counter (stall_cnt).
module pipe_stage_buf #(
  parameter int            DW      = 65,
  parameter logic [DW-1:0] RST_VAL = '0
`ifdef PIPE_STAGE_PERF_EN
  , parameter int          CW      = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_buf_if.slave  up,
  pipe_stage_buf_if.master dn,
  output logic [1:0]       occ
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CW-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_main;
  logic [DW-1:0] r_skid;

  logic w_in_ready;
  logic w_out_valid;
  logic w_acc;
  logic w_pop;

  // Both flags decode from the state register alone, so out_ready never reaches in_ready.
  assign w_in_ready  = (r_state != FULL);
  assign w_out_valid = (r_state != EMPTY);
  assign w_acc       = up.valid & w_in_ready;
  assign w_pop       = w_out_valid & dn.ready;

  assign up.ready = w_in_ready;
  assign dn.valid = w_out_valid;
  assign dn.data  = r_main;
  assign occ      = r_state;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state <= EMPTY;
      r_main  <= RST_VAL;
      r_skid  <= RST_VAL;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            r_state <= HALF;
            r_main  <= up.data;
          end
        end
        HALF: begin
          if (w_acc && !w_pop) begin
            r_state <= FULL;
            r_skid  <= up.data;
          end else if (w_acc && w_pop) begin
            r_main  <= up.data;
          end else if (w_pop) begin
            r_state <= EMPTY;
            r_main  <= RST_VAL;
          end
        end
        FULL: begin
          // Skid entry is older than any new arrival; in_ready is 0 here so nothing is accepted.
          if (w_pop) begin
            r_state <= HALF;
            r_main  <= r_skid;
            r_skid  <= RST_VAL;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_main  <= RST_VAL;
          r_skid  <= RST_VAL;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] r_stall_cnt;

  // Flush leaves the count alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !dn.ready && (r_stall_cnt != {CW{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CW'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus random traffic against a queue model.
// Build with +define+PIPE_STAGE_PERF_EN to also exercise stall_cnt (CW=2).
module tb_pipe_stage_buf;
  localparam int            DW      = 16;
  localparam logic [DW-1:0] RST_VAL = 16'hDEAD;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [1:0] occ;
`ifdef PIPE_STAGE_PERF_EN
  logic [1:0] stall_cnt;
  logic [1:0] exp_stall;
`endif

  pipe_stage_buf_if #(.DW(DW)) up_if ();
  pipe_stage_buf_if #(.DW(DW)) dn_if ();

  pipe_stage_buf #(
    .DW      (DW),
    .RST_VAL (RST_VAL)
`ifdef PIPE_STAGE_PERF_EN
    , .CW    (2)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .up    (up_if),
    .dn    (dn_if),
    .occ   (occ)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  // clock/reset block
  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  logic          mon_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic rdy);
    up_if.valid = v;
    up_if.data  = d;
    dn_if.ready = rdy;
  endtask

  // scoreboard: checks at the falling edge, then applies this cycle's handshakes to the model
  always @(negedge clk) begin
    if (mon_en) begin
      logic acc;
      logic pop;
      check_eq("occ", 32'(occ), 32'(exp_q.size()));
      check_eq("out_valid", 32'(dn_if.valid), 32'(exp_q.size() != 0));
      check_eq("in_ready", 32'(up_if.ready), 32'(exp_q.size() != 2));
      if (exp_q.size() == 0)
        check_eq("out_data_empty", 32'(dn_if.data), 32'(RST_VAL));
      else
        check_eq("out_data", 32'(dn_if.data), 32'(exp_q[0]));
`ifdef PIPE_STAGE_PERF_EN
      check_eq("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      if (reset)
        exp_stall = 2'd0;
      else if ((exp_q.size() != 0) && !dn_if.ready && (exp_stall != 2'd3))
        exp_stall = exp_stall + 2'd1;
`endif
      acc = up_if.valid && (exp_q.size() < 2);
      pop = dn_if.ready && (exp_q.size() > 0);
      if (reset || flush) begin
        exp_q.delete();
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(up_if.data);
      end
    end
  end

  initial begin
    // 1. reset held two cycles with in_valid high
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b1, 16'h0BAD, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    exp_stall = 2'd0;
`endif
    step();
    mon_en = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 16'h0000, 1'b1);
    step();

    // 2. streaming with out_ready held high
    drive(1'b1, 16'h0011, 1'b1); step();
    drive(1'b1, 16'h0022, 1'b1); step();
    drive(1'b1, 16'h0033, 1'b1); step();
    drive(1'b0, 16'h0000, 1'b1); step(2);

    // 3. backpressure: fill both entries, then drain
    drive(1'b1, 16'h00AA, 1'b0); step();
    drive(1'b1, 16'h00BB, 1'b0); step();
    drive(1'b1, 16'h00CC, 1'b0); step(2);
    drive(1'b0, 16'h0000, 1'b1); step(3);

    // 4. flush while FULL with in_valid and out_ready high
    drive(1'b1, 16'h0101, 1'b0); step();
    drive(1'b1, 16'h0202, 1'b0); step();
    drive(1'b1, 16'h0303, 1'b1);
    flush = 1'b1; step();
    flush = 1'b0;
    drive(1'b0, 16'h0000, 1'b1); step(2);

    // 5. reset and flush together while HALF, then normal acceptance
    drive(1'b1, 16'h0404, 1'b0); step();
    drive(1'b1, 16'h0505, 1'b0);
    reset = 1'b1; flush = 1'b1; step();
    reset = 1'b0; flush = 1'b0;
    drive(1'b1, 16'h0606, 1'b1); step();
    drive(1'b0, 16'h0000, 1'b1); step(2);

`ifdef PIPE_STAGE_PERF_EN
    // 6. stall counter saturation and flush persistence
    reset = 1'b1; step();
    reset = 1'b0;
    drive(1'b1, 16'h0707, 1'b0); step();
    drive(1'b0, 16'h0000, 1'b0); step(5);
    check_eq("stall_sat", 32'(stall_cnt), 32'd3);
    flush = 1'b1; step();
    flush = 1'b0; step();
    check_eq("stall_after_flush", 32'(stall_cnt), 32'd3);
    drive(1'b0, 16'h0000, 1'b1); step();
`endif

    // random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 16'hFFFF)),
            1'($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 39) == 0);
      step();
    end
    flush = 1'b0;

    // drain with a bounded cycle budget
    drive(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    step();
    check_eq("drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
